// File: rtl/fifo_sync_flags_pkg.sv
// Shared constants and helpers for the synchronous flag FIFO family.
package fifo_pkg;

    localparam int FIFO_STD      = 0;
    localparam int FIFO_FWFT     = 1;
    localparam int AE_THRESH_DEF = 2;
    localparam int AF_MARGIN_DEF = 2;

    // Width needed to count 0..depth inclusive.
    function automatic int lvl_w(input int depth);
        return $clog2(depth + 1);
    endfunction

endpackage

// File: rtl/fifo_sync_flags_ptr_wrap.sv
// Pointer that counts 0..DEPTH-1 and wraps explicitly, so DEPTH need not be a power of two.
module fifo_ptr_wrap #(
    parameter  int DEPTH = 16,
    localparam int PW    = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          clr,
    input  logic          inc,
    output logic [PW-1:0] ptr
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            ptr <= '0;
        else if (clr)
            ptr <= '0;
        else if (inc)
            ptr <= (ptr == PW'(DEPTH - 1)) ? '0 : ptr + 1'b1;
    end

endmodule

// File: rtl/fifo_sync_flags.sv
// Single-clock FIFO with optional FWFT output stage, fill level, thresholds,
// sticky overflow/underflow and synchronous flush.
module fifo_sync_flags
    import fifo_pkg::*;
#(
    parameter  int DATA_WIDTH = 8,
    parameter  int DEPTH      = 16,
    parameter  int FWFT       = FIFO_STD,
    parameter  int AF_THRESH  = DEPTH - AF_MARGIN_DEF,
    parameter  int AE_THRESH  = AE_THRESH_DEF,
    localparam int LW         = lvl_w(DEPTH),
    localparam int PW         = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  flush,
    input  logic                  wr_en,
    input  logic [DATA_WIDTH-1:0] din,
    output logic                  full,
    output logic                  almost_full,
    input  logic                  rd_en,
    output logic [DATA_WIDTH-1:0] dout,
    output logic                  empty,
    output logic                  almost_empty,
    output logic [LW-1:0]         level,
    output logic                  overflow,
    output logic                  underflow
);

    if (DATA_WIDTH < 1 || DEPTH < 2 || AE_THRESH < 0 ||
        AE_THRESH >= AF_THRESH || AF_THRESH > DEPTH) begin : g_bad_params
        $error("fifo_sync_flags: illegal DATA_WIDTH/DEPTH/threshold combination");
    end

    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]         wr_ptr, rd_ptr;
    logic [LW-1:0]         level_q;
    logic [DATA_WIDTH-1:0] dout_q;
    logic                  ov_q, un_q;
    logic                  rd_acc, wr_acc, mem_we, rd_inc;

    assign full         = (level_q == LW'(DEPTH));
    assign almost_full  = (level_q >= LW'(AF_THRESH));
    assign almost_empty = (level_q <= LW'(AE_THRESH));
    assign level        = level_q;
    assign dout         = dout_q;
    assign overflow     = ov_q;
    assign underflow    = un_q;

    // Flush masks both requests so they neither move state nor raise errors.
    assign rd_acc = !flush & rd_en & !empty;
    assign wr_acc = !flush & wr_en & (!full | rd_acc);

    fifo_ptr_wrap #(.DEPTH(DEPTH)) u_wr_ptr (
        .clk(clk), .rst_n(rst_n), .clr(flush), .inc(mem_we), .ptr(wr_ptr)
    );

    fifo_ptr_wrap #(.DEPTH(DEPTH)) u_rd_ptr (
        .clk(clk), .rst_n(rst_n), .clr(flush), .inc(rd_inc), .ptr(rd_ptr)
    );

    always_ff @(posedge clk) begin
        if (mem_we)
            mem[wr_ptr] <= din;
    end

    if (FWFT == FIFO_FWFT) begin : g_fwft
        logic          out_valid;
        logic [LW-1:0] mem_cnt;
        logic          take, bypass, load_mem;

        // level includes the output register; the array holds the remainder.
        assign mem_cnt  = level_q - LW'(out_valid);
        assign take     = !out_valid | rd_acc;
        assign bypass   = wr_acc & take & (mem_cnt == '0);
        assign load_mem = take & (mem_cnt != '0);
        assign mem_we   = wr_acc & !bypass;
        assign rd_inc   = load_mem & !flush;
        assign empty    = !out_valid;

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                out_valid <= 1'b0;
                dout_q    <= '0;
            end else if (flush) begin
                out_valid <= 1'b0;
            end else if (load_mem) begin
                dout_q    <= mem[rd_ptr];
                out_valid <= 1'b1;
            end else if (bypass) begin
                dout_q    <= din;
                out_valid <= 1'b1;
            end else if (rd_acc) begin
                out_valid <= 1'b0;
            end
        end
    end else begin : g_std
        assign mem_we = wr_acc;
        assign rd_inc = rd_acc;
        assign empty  = (level_q == '0);

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n)
                dout_q <= '0;
            else if (rd_acc)
                dout_q <= mem[rd_ptr];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            level_q <= '0;
        else if (flush)
            level_q <= '0;
        else if (wr_acc && !rd_acc)
            level_q <= level_q + 1'b1;
        else if (rd_acc && !wr_acc)
            level_q <= level_q - 1'b1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ov_q <= 1'b0;
            un_q <= 1'b0;
        end else if (flush) begin
            ov_q <= 1'b0;
            un_q <= 1'b0;
        end else begin
            if (wr_en && !wr_acc) ov_q <= 1'b1;
            if (rd_en && empty)   un_q <= 1'b1;
        end
    end

endmodule
